// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake: the sequencer raises imem_req in FETCH,
// memory answers with imem_ack and the instruction word on instr_in.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic             imem_ack;
  logic [WIDTH-1:0] instr_in;

  modport master (output imem_req, input imem_ack, input instr_in);
  modport slave  (input imem_req, output imem_ack, output instr_in);
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/WB control FSM with IR, fetch timeout and halt/resume.
// Optional performance counters are built when PC_SEQ_PERF_CNT_EN is defined.
module pc_sequencer #(
  parameter int WIDTH        = 32,
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  pc_sequencer_if.master        imem,
  output logic [WIDTH-1:0]      ir,
  input  logic                  eq,
  output logic                  pc_en,
  output logic                  pcsrc,
  output logic                  regwrite,
  output logic                  halted,
  output logic                  fault,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instret_cnt
);

  localparam int TW = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(IMEM_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] ir_reg, ir_next;
  logic [TW-1:0]    timer_reg, timer_next;
  logic             fault_reg, fault_next;
  logic             is_br_reg, is_br_next;
  logic             is_jal_reg, is_jal_next;
  logic             taken_reg, taken_next;
  logic             br_taken;

  // beq taken on equal, bne on not-equal; every other funct3 falls through
  assign br_taken = ((ir_reg[14:12] == 3'b000) &  eq) |
                    ((ir_reg[14:12] == 3'b001) & ~eq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      ir_reg     <= '0;
      timer_reg  <= '0;
      fault_reg  <= 1'b0;
      is_br_reg  <= 1'b0;
      is_jal_reg <= 1'b0;
      taken_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ir_reg     <= ir_next;
      timer_reg  <= timer_next;
      fault_reg  <= fault_next;
      is_br_reg  <= is_br_next;
      is_jal_reg <= is_jal_next;
      taken_reg  <= taken_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ir_next     = ir_reg;
    timer_next  = '0;
    fault_next  = fault_reg;
    is_br_next  = is_br_reg;
    is_jal_next = is_jal_reg;
    taken_next  = taken_reg;
    case (state_reg)
      IDLE:   state_next = halt ? HALT : FETCH;
      FETCH: begin
        if (imem.imem_ack) begin
          ir_next    = imem.instr_in;
          state_next = DECODE;
        end else if (timer_reg == TIMER_LAST) begin
          // ack given up on: fault is sticky, only rst leaves HALT afterwards
          fault_next = 1'b1;
          state_next = HALT;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      DECODE: begin
        is_br_next  = (ir_reg[6:0] == 7'b1100011);
        is_jal_next = (ir_reg[6:0] == 7'b1101111);
        state_next  = EXEC;
      end
      EXEC: begin
        taken_next = is_jal_reg | (is_br_reg & br_taken);
        state_next = WB;
      end
      WB:     state_next = halt ? HALT : FETCH;
      HALT:   if (!fault_reg && !halt) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode from state only, so an asynchronous reset clears them at once
  assign imem.imem_req = (state_reg == FETCH);
  assign pc_en         = (state_reg == WB);
  assign pcsrc         = pc_en & taken_reg;
  assign regwrite      = pc_en & ~is_br_reg;
  assign halted        = (state_reg == HALT);
  assign fault         = fault_reg;
  assign ir            = ir_reg;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_reg;
  logic [31:0] instret_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (state_reg == WB) instret_cnt_reg <= instret_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
